// File: rtl/preg_file_sb.sv
// Physical register file with 1-cycle registered read, wb/we forwarding and a busy scoreboard.
// Define PREG_FILE_SCOREBOARD_EN to build the busy table; otherwise chk_rdy is constant 1.
module preg_file_sb #(
    parameter  int XLEN       = 32,
    parameter  int PREG_SIZE  = 128,
    parameter  int READ_PORT  = 8,
    parameter  int WRITE_PORT = 4,
    parameter  int WB_SIZE    = 4,
    parameter  int ALLOC_PORT = 4,
    parameter  int CHK_PORT   = 8,
    localparam int PREG_WIDTH = $clog2(PREG_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [READ_PORT-1:0]                  en,
    input  logic [READ_PORT-1:0][PREG_WIDTH-1:0]  raddr,
    output logic [READ_PORT-1:0][XLEN-1:0]        rdata,
    input  logic [WRITE_PORT-1:0]                 we,
    input  logic [WRITE_PORT-1:0][PREG_WIDTH-1:0] waddr,
    input  logic [WRITE_PORT-1:0][XLEN-1:0]       wdata,
    input  logic [WB_SIZE-1:0]                    wb_en,
    input  logic [WB_SIZE-1:0][PREG_WIDTH-1:0]    wb_rd,
    input  logic [WB_SIZE-1:0][XLEN-1:0]          wb_res,
    input  logic [ALLOC_PORT-1:0]                 alloc_en,
    input  logic [ALLOC_PORT-1:0][PREG_WIDTH-1:0] alloc_preg,
    input  logic                                  flush,
    input  logic [CHK_PORT-1:0][PREG_WIDTH-1:0]   chk_addr,
    output logic [CHK_PORT-1:0]                   chk_rdy
);

    typedef enum logic [1:0] {SEL_ZERO, SEL_BYP, SEL_MEM} rsel_e;

    logic [XLEN-1:0] r_mem [PREG_SIZE];
    rsel_e           r_sel [READ_PORT];
    logic [XLEN-1:0] r_byp [READ_PORT];
    logic [XLEN-1:0] r_sto [READ_PORT];
    rsel_e           w_sel [READ_PORT];
    logic [XLEN-1:0] w_byp [READ_PORT];

    // Later assignments win: highest we lane, then lowest wb lane overrides, then preg 0.
    always_comb begin
        for (int p = 0; p < READ_PORT; p++) begin
            w_sel[p] = SEL_MEM;
            w_byp[p] = '0;
            for (int l = 0; l < WRITE_PORT; l++) begin
                if (we[l] && waddr[l] == raddr[p]) begin
                    w_sel[p] = SEL_BYP;
                    w_byp[p] = wdata[l];
                end
            end
            for (int l = WB_SIZE - 1; l >= 0; l--) begin
                if (wb_en[l] && wb_rd[l] == raddr[p]) begin
                    w_sel[p] = SEL_BYP;
                    w_byp[p] = wb_res[l];
                end
            end
            if (raddr[p] == '0) begin
                w_sel[p] = SEL_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < READ_PORT; p++) begin
                r_sel[p] <= SEL_ZERO;
                r_byp[p] <= '0;
                r_sto[p] <= '0;
            end
            for (int a = 0; a < PREG_SIZE; a++) begin
                r_mem[a] <= '0;
            end
        end else begin
            for (int p = 0; p < READ_PORT; p++) begin
                if (en[p]) begin
                    r_sel[p] <= w_sel[p];
                    r_byp[p] <= w_byp[p];
                    r_sto[p] <= r_mem[raddr[p]];
                end
            end
            for (int l = 0; l < WRITE_PORT; l++) begin
                if (we[l] && waddr[l] != '0) begin
                    r_mem[waddr[l]] <= wdata[l];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < READ_PORT; p++) begin
            case (r_sel[p])
                SEL_ZERO: rdata[p] = '0;
                SEL_BYP:  rdata[p] = r_byp[p];
                default:  rdata[p] = r_sto[p];
            endcase
        end
    end

    for (genvar a = 0; a < WRITE_PORT; a++) begin : g_wr_chk_a
        for (genvar b = a + 1; b < WRITE_PORT; b++) begin : g_wr_chk_b
            a_no_dup_write: assert property (@(posedge clk) disable iff (rst)
                !(we[a] && we[b] && waddr[a] == waddr[b]));
        end
    end

`ifdef PREG_FILE_SCOREBOARD_EN
    logic [PREG_SIZE-1:0] r_busy;

    // Clears first, sets after, so an alloc beats a wb on the same preg.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy <= '0;
        end else begin
            for (int l = 0; l < WB_SIZE; l++) begin
                if (wb_en[l]) r_busy[wb_rd[l]] <= 1'b0;
            end
            for (int l = 0; l < ALLOC_PORT; l++) begin
                if (alloc_en[l]) r_busy[alloc_preg[l]] <= 1'b1;
            end
            r_busy[0] <= 1'b0;
        end
    end

    always_comb begin
        for (int j = 0; j < CHK_PORT; j++) begin
            chk_rdy[j] = (chk_addr[j] == '0) || !r_busy[chk_addr[j]];
            for (int l = 0; l < WB_SIZE; l++) begin
                if (wb_en[l] && wb_rd[l] == chk_addr[j]) chk_rdy[j] = 1'b1;
            end
        end
    end
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{alloc_en, alloc_preg, flush, chk_addr};
    assign chk_rdy     = '1;
`endif

endmodule

// File: tb/tb_preg_file_sb.sv
// Bench for preg_file_sb: vector table plus hand sequences, read results checked via an expect queue.
// Scoreboard cases follow PREG_FILE_SCOREBOARD_EN as seen by this compile.
module tb_preg_file_sb;
    localparam int XLEN = 32, PS = 128, PW = 7, RP = 8, WP = 4, WB = 4, AP = 4, CP = 8;

    logic clk = 1'b0;
    logic rst;
    logic [RP-1:0]          en;
    logic [RP-1:0][PW-1:0]  raddr;
    logic [RP-1:0][XLEN-1:0] rdata;
    logic [WP-1:0]          we;
    logic [WP-1:0][PW-1:0]  waddr;
    logic [WP-1:0][XLEN-1:0] wdata;
    logic [WB-1:0]          wb_en;
    logic [WB-1:0][PW-1:0]  wb_rd;
    logic [WB-1:0][XLEN-1:0] wb_res;
    logic [AP-1:0]          alloc_en;
    logic [AP-1:0][PW-1:0]  alloc_preg;
    logic                   flush;
    logic [CP-1:0][PW-1:0]  chk_addr;
    logic [CP-1:0]          chk_rdy;

    preg_file_sb dut (
        .clk(clk), .rst(rst), .en(en), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_res(wb_res),
        .alloc_en(alloc_en), .alloc_preg(alloc_preg), .flush(flush),
        .chk_addr(chk_addr), .chk_rdy(chk_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          we_l;
        logic [6:0]  waddr;
        logic [31:0] wdata;
        int          wb_l;
        logic [6:0]  wb_rd;
        logic [31:0] wb_res;
        int          rp;
        logic [6:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        en = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        wb_en = '0; wb_rd = '0; wb_res = '0;
        alloc_en = '0; alloc_preg = '0; flush = 1'b0; chk_addr = '0;
    endtask

    task automatic rd(input int p, input logic [6:0] a, input logic [31:0] e, input string n);
        en[p] = 1'b1;
        raddr[p] = a;
        exp_q.push_back('{p, e, n});
    endtask

    // Advance one cycle and compare every read issued in the previous cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, rdata[e.port], e.exp);
        end
    endtask

    task automatic chk(input int j, input logic [6:0] a, input logic e, input string n);
        chk_addr[j] = a;
        #1;
        check(n, {31'b0, chk_rdy[j]}, {31'b0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 7,   32'hDEADBEEF, -1, 0,   0,        3, 7,   32'hDEADBEEF};
        vecs[1] = '{-1, 0,  0,            -1, 0,   0,        2, 7,   32'hDEADBEEF};
        vecs[2] = '{0, 9,   32'h11,       -1, 0,   0,        1, 9,   32'h11};
        vecs[3] = '{3, 9,   32'h22,        1, 9,   32'h55,   4, 9,   32'h55};
        vecs[4] = '{-1, 0,  0,            -1, 0,   0,        5, 9,   32'h22};
        vecs[5] = '{2, 0,   32'hFFFF,      0, 0,   32'h1234, 6, 0,   32'h0};
        vecs[6] = '{-1, 0,  0,            -1, 0,   0,        7, 0,   32'h0};
        vecs[7] = '{2, 127, 32'hA5A5A5A5, -1, 0,   0,        0, 127, 32'hA5A5A5A5};
        vecs[8] = '{-1, 0,  0,             3, 127, 32'h77,   0, 127, 32'h77};
        vecs[9] = '{-1, 0,  0,            -1, 0,   0,        1, 127, 32'hA5A5A5A5};

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < RP; p++) check($sformatf("reset_rdata%0d", p), rdata[p], 32'h0);
        for (int j = 0; j < CP; j++) chk(j, 7'(j * 18 + 1), 1'b1, $sformatf("reset_chk%0d", j));
        idle();
        rd(0, 5, 32'h0, "reset_read5");
        tick();

        for (int i = 0; i < 10; i++) begin
            idle();
            if (vecs[i].we_l >= 0) begin
                we[vecs[i].we_l] = 1'b1;
                waddr[vecs[i].we_l] = vecs[i].waddr;
                wdata[vecs[i].we_l] = vecs[i].wdata;
            end
            if (vecs[i].wb_l >= 0) begin
                wb_en[vecs[i].wb_l] = 1'b1;
                wb_rd[vecs[i].wb_l] = vecs[i].wb_rd;
                wb_res[vecs[i].wb_l] = vecs[i].wb_res;
            end
            rd(vecs[i].rp, vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
            tick();
        end

        // lowest wb lane beats higher wb lanes, wb beats we, we beats storage
        idle();
        we[0] = 1'b1; waddr[0] = 9; wdata[0] = 32'h11;
        tick();
        idle();
        we[0] = 1'b1; waddr[0] = 9; wdata[0] = 32'h22;
        wb_en[2] = 1'b1; wb_rd[2] = 9; wb_res[2] = 32'h33;
        wb_en[3] = 1'b1; wb_rd[3] = 9; wb_res[3] = 32'h44;
        rd(0, 9, 32'h33, "bypass_prio");
        tick();

        // all ports in one cycle, port 7 fed by wb
        idle();
        wb_en[0] = 1'b1; wb_rd[0] = 5; wb_res[0] = 32'hCAFE;
        rd(0, 7, 32'hDEADBEEF, "multi0");
        rd(1, 9, 32'h22, "multi1");
        rd(2, 127, 32'hA5A5A5A5, "multi2");
        rd(3, 0, 32'h0, "multi3");
        rd(4, 7, 32'hDEADBEEF, "multi4");
        rd(5, 9, 32'h22, "multi5");
        rd(6, 127, 32'hA5A5A5A5, "multi6");
        rd(7, 5, 32'hCAFE, "multi7");
        tick();

        // en=0 keeps rdata even though storage changes
        idle();
        we[0] = 1'b1; waddr[0] = 7; wdata[0] = 32'h99;
        tick();
        check("hold0", rdata[0], 32'hDEADBEEF);
        check("hold2", rdata[2], 32'hA5A5A5A5);
        tick();
        check("hold7", rdata[7], 32'hCAFE);

        // reset discards an in-flight read and zeroes storage
        idle();
        rst = 1'b1;
        rd(0, 7, 32'h0, "rst_inflight");
        tick();
        check("rst_rdata7", rdata[7], 32'h0);
        rst = 1'b0;
        idle();
        rd(1, 7, 32'h0, "rst_mem7");
        rd(2, 127, 32'h0, "rst_mem127");
        tick();

`ifdef PREG_FILE_SCOREBOARD_EN
        idle();
        alloc_en[0] = 1'b1; alloc_preg[0] = 20;
        chk(0, 20, 1'b1, "sb_alloc_same_cycle");
        tick();
        idle(); chk(0, 20, 1'b0, "sb_busy_t1"); tick();
        idle(); chk(0, 20, 1'b0, "sb_busy_t2"); tick();
        idle();
        wb_en[1] = 1'b1; wb_rd[1] = 20; wb_res[1] = 32'h1;
        chk(0, 20, 1'b1, "sb_wb_same_cycle");
        tick();
        idle(); chk(0, 20, 1'b1, "sb_cleared"); tick();
        idle();
        alloc_en[1] = 1'b1; alloc_preg[1] = 21;
        wb_en[0] = 1'b1; wb_rd[0] = 21;
        tick();
        idle(); chk(1, 21, 1'b0, "sb_set_beats_clear"); tick();
        idle();
        flush = 1'b1;
        alloc_en[2] = 1'b1; alloc_preg[2] = 22;
        tick();
        idle();
        chk(0, 22, 1'b1, "sb_flush_over_alloc");
        chk(1, 21, 1'b1, "sb_flush_clears");
        tick();
        idle();
        alloc_en[0] = 1'b1; alloc_preg[0] = 0;
        tick();
        idle(); chk(0, 0, 1'b1, "sb_preg0"); tick();
        idle();
        alloc_en[3] = 1'b1; alloc_preg[3] = 30;
        tick();
        idle(); chk(2, 30, 1'b0, "sb_busy30"); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(); chk(2, 30, 1'b1, "sb_reset_clears"); tick();
`else
        idle();
        alloc_en[0] = 1'b1; alloc_preg[0] = 20;
        chk(0, 20, 1'b1, "nosb_t0");
        tick();
        idle(); chk(0, 20, 1'b1, "nosb_t1"); tick();
        idle(); chk(3, 20, 1'b1, "nosb_t2"); tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/preg_file_sb.md
# preg_file_sb

Parametrised physical register file for the integer backend: multi-port storage with one-cycle synchronous read, write-first forwarding and same-cycle write-back bypass. It also holds a physical-register busy scoreboard that rename sets and write-back clears. It sits between rename/dispatch (scoreboard) and the issue queues/execution units (operand read), replacing the fixed-size register file with a configurable one.

## Interface
- XLEN, 32, data width
- PREG_SIZE, 128, number of physical registers; PREG_WIDTH = $clog2(PREG_SIZE)
- READ_PORT, 8, operand read ports
- WRITE_PORT, 4, storage write ports
- WB_SIZE, 4, write-back bus lanes (bypass and scoreboard clear)
- ALLOC_PORT, 4, rename allocation lanes (scoreboard set)
- CHK_PORT, 8, scoreboard query ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  READ_PORT  read enable per port
- raddr  in  READ_PORT×PREG_WIDTH  read address
- rdata  out  READ_PORT×XLEN  read data, one cycle after en
- we  in  WRITE_PORT  write enable
- waddr  in  WRITE_PORT×PREG_WIDTH  write address
- wdata  in  WRITE_PORT×XLEN  write data
- wb_en  in  WB_SIZE  write-back lane valid
- wb_rd  in  WB_SIZE×PREG_WIDTH  write-back destination
- wb_res  in  WB_SIZE×XLEN  write-back result
- alloc_en  in  ALLOC_PORT  allocation valid
- alloc_preg  in  ALLOC_PORT×PREG_WIDTH  newly allocated destination
- flush  in  1  backend flush; clears the scoreboard
- chk_addr  in  CHK_PORT×PREG_WIDTH  scoreboard query address
- chk_rdy  out  CHK_PORT  1 means the register value is available

## Operation
- Storage: PREG_SIZE×XLEN flops, all zero after reset. Each we lane writes waddr at the clock edge.
- Preg 0 is hardwired zero. Writes to it are ignored, reads return 0, and it is never busy.
- Two write lanes targeting the same address in one cycle is illegal; an assertion fires. RTL resolves it as the highest lane index wins.
- Read, port i, en=1 in cycle T: rdata[i] in T+1 is selected by this priority:
  - 0 if raddr = 0;
  - else wb_res of the lowest-index wb lane with wb_en and wb_rd = raddr in T;
  - else wdata of the highest-index we lane with waddr = raddr in T (write-first);
  - else storage[raddr].
- With en=0 in cycle T, rdata[i] holds its previous value in T+1.
- Scoreboard: busy[PREG_SIZE], all 0 after reset.
  - alloc_en lane sets busy[alloc_preg].
  - wb_en lane clears busy[wb_rd].
  - Set beats clear for the same preg in the same cycle.
  - flush clears every busy bit and overrides alloc in the same cycle.
- chk_rdy[j] (combinational) = (chk_addr = 0) | !busy[chk_addr] | any wb_en lane with wb_rd = chk_addr this cycle. Same-cycle alloc is not visible until the next cycle.

## Timing
- Read latency: exactly 1 cycle. raddr, the wb match and the we match are registered into a per-port bypass select and data stage. The storage read is also registered.
- Write: visible in storage from T+1. A same-cycle read sees it through write-first forwarding.
- Scoreboard update: takes effect at the edge; chk_rdy reflects the new state from T+1. chk_rdy includes the same-cycle wb path.
- Reset in any cycle:
  - next cycle: rdata = 0, all busy = 0, chk_rdy = 1 for every address;
  - storage is zeroed;
  - in-flight read results are discarded.
- No handshake or backpressure: every port accepts every cycle.

## Configuration
- PREG_FILE_SCOREBOARD_EN defined: busy table, alloc/flush logic and chk_rdy are built as above.
- PREG_FILE_SCOREBOARD_EN undefined: no busy flops, chk_rdy is tied to all 1s, alloc_en/alloc_preg/flush are ignored. Read and write behaviour is unchanged.

## Test plan
- Reset then read: rst for 2 cycles, en[0]=1, raddr=5 → rdata[0]=0 next cycle; chk_rdy for every address = 1.
- Write then read: we[1]=1, waddr=7, wdata=0xDEADBEEF in T.
  - en[2], raddr=7 in T+1 → rdata[2]=0xDEADBEEF in T+2.
  - en[3], raddr=7 in T → rdata[3]=0xDEADBEEF in T+1 (write-first).
- Bypass priority: in one cycle, storage[9]=0x11, we[0] (9, 0x22), wb_en[2] (9, 0x33), wb_en[3] (9, 0x44), read raddr=9 → rdata=0x33.
- Zero register: we to preg 0 with 0xFFFF, wb to preg 0 with 0x1234, read preg 0 → rdata=0; chk_rdy for preg 0 = 1 after alloc of preg 0.
- Scoreboard (macro defined):
  - alloc preg 20 in T → chk_rdy(20)=0 in T+1;
  - wb_rd=20 in T+3 → chk_rdy(20)=1 in T+3 (same-cycle path) and stays 1;
  - alloc and wb of preg 21 in the same cycle → busy;
  - flush with alloc preg 22 → chk_rdy(22)=1.
- Macro undefined: alloc preg 20 → chk_rdy(20)=1 every cycle; read/write vectors from the earlier tests give identical results.
